// File: rtl/reg_file_arbiter.sv
// Two-port round-robin arbiter/sequencer sharing one 4x4 register file.
// Each granted request runs IDLE -> ACCESS -> RESP and completes with a one-cycle ack.
module reg_file_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] file_in,
  output logic [ADDR_W-1:0] file_waddr,
  output logic [ADDR_W-1:0] file_raddr,
  output logic              file_write,
  input  logic [DATA_W-1:0] file_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              lat_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              pick;

  // Port 1 wins when it requests alone, or on a tie when port 0 was served last.
  always_comb begin
    pick = req1 && (!req0 || !last_grant);
  end

  assign file_waddr = lat_addr;
  assign file_raddr = lat_addr;
  assign file_in    = lat_wdata;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
      file_write <= 1'b0;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (req0 || req1) begin
            lat_id     <= pick;
            lat_we     <= pick ? we1 : we0;
            lat_addr   <= pick ? addr1 : addr0;
            lat_wdata  <= pick ? wdata1 : wdata0;
            file_write <= pick ? we1 : we0;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          file_write <= 1'b0;
          if (!lat_we) begin
            if (lat_id) rdata1 <= file_out;
            else        rdata0 <= file_out;
          end
          ack0  <= !lat_id;
          ack1  <= lat_id;
          state <= RESP;
        end
        RESP: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          busy       <= 1'b0;
          last_grant <= lat_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter: directed sequences, a vector table,
// and randomized traffic checked against a transaction-level model.
module tb_reg_file_arbiter;

  logic       clk = 1'b0;
  logic       clr;
  logic       req0, we0, req1, we1;
  logic [1:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [3:0] rdata0, rdata1;
  logic [3:0] file_in, file_out;
  logic [1:0] file_waddr, file_raddr;
  logic       file_write, busy;

  int tests = 0;
  int fails = 0;

  // Register file attached to the arbiter: synchronous write, combinational read.
  logic [3:0] mem [4] = '{default: 4'h0};
  always @(posedge clk) if (file_write) mem[file_waddr] <= file_in;
  assign file_out = mem[file_raddr];

  always #5 clk = ~clk;

  reg_file_arbiter #(.DATA_W(4), .ADDR_W(2)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .file_in(file_in), .file_waddr(file_waddr), .file_raddr(file_raddr),
    .file_write(file_write), .file_out(file_out), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits for an ack; port = 0/1, 2 if both fired, -1 on timeout.
  task automatic wait_ack(output int port, output int cycles);
    bit found = 0;
    port = -1;
    cycles = 9;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        found = 1;
        cycles = i;
        port = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
      end
    end
  endtask

  task automatic drive(input bit r0, input bit w0, input int a0, input int d0,
                       input bit r1, input bit w1, input int a1, input int d1);
    req0 = r0; we0 = w0; addr0 = 2'(a0); wdata0 = 4'(d0);
    req1 = r1; we1 = w1; addr1 = 2'(a1); wdata1 = 4'(d1);
  endtask

  typedef struct {
    bit r0; bit w0; int a0; int d0;
    bit r1; bit w1; int a1; int d1;
    int exp_port;
    int exp_rdata;   // -1 when the winner writes
  } vec_t;

  vec_t vecs [9];
  int   port, cyc;
  int   ack_cyc [4];
  int   ack_port [4];
  int   nacks;

  // Transaction-level model state
  logic [3:0] shadow [4];
  bit  pend [2];
  bit  op_we [2];
  int  op_addr [2];
  int  op_data [2];
  int  model_last;
  bit  just_acked;
  int  winner, exp_lat;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    clr = 1'b1;

    // Reset with both requests held high
    tick();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_busy", busy, 0);
      check("rst_fwrite", file_write, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
    end
    clr = 1'b0;
    wait_ack(port, cyc);
    check("first_grant_port", port, 0);
    check("first_grant_latency", cyc, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Port 0 write 0xA to addr 2, cycle-exact
    drive(1, 1, 2, 10, 0, 0, 0, 0);
    tick();
    check("wr_fwrite_access", file_write, 1);
    check("wr_waddr", file_waddr, 2);
    check("wr_file_in", file_in, 10);
    check("wr_busy_access", busy, 1);
    check("wr_ack0_access", ack0, 0);
    tick();
    check("wr_ack0_resp", ack0, 1);
    check("wr_fwrite_resp", file_write, 0);
    check("wr_busy_resp", busy, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("wr_ack0_after", ack0, 0);
    check("wr_busy_after", busy, 0);
    check("wr_fwrite_after", file_write, 0);

    // Port 1 reads back addr 2
    drive(0, 0, 0, 0, 1, 0, 2, 0);
    tick();
    check("rd_raddr", file_raddr, 2);
    check("rd_fwrite", file_write, 0);
    tick();
    check("rd_ack1", ack1, 1);
    check("rd_rdata1", rdata1, 10);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("rd_ack1_drop", ack1, 0);
    check("rd_rdata1_hold", rdata1, 10);
    check("rd_fwrite_after", file_write, 0);

    // Both held continuously: strict alternation every 3 cycles
    drive(1, 1, 0, 3, 1, 1, 1, 4);
    nacks = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if ((ack0 || ack1) && nacks < 4) begin
        ack_cyc[nacks] = i;
        ack_port[nacks] = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        nacks++;
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("alt_count", nacks, 4);
    for (int k = 0; k < nacks; k++) begin
      check("alt_port", ack_port[k], k % 2);
      check("alt_cycle", ack_cyc[k], 2 + 3 * k);
    end

    // clr during ACCESS aborts a port 0 read of addr 1
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    check("abort_busy_access", busy, 1);
    clr = 1'b1;
    tick();
    check("abort_ack0", ack0, 0);
    check("abort_busy", busy, 0);
    check("abort_rdata0", rdata0, 0);
    clr = 1'b0;
    tick();
    check("reissue_ack0_early", ack0, 0);
    tick();
    check("reissue_ack0", ack0, 1);
    check("reissue_rdata0", rdata0, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Vector table, starting from reset so port 0 wins the first tie
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vecs[0] = '{1, 1, 2, 10, 0, 0, 0, 0,  0, -1};
    vecs[1] = '{0, 0, 0, 0,  1, 0, 2, 0,  1, 10};
    vecs[2] = '{1, 1, 3, 5,  1, 0, 3, 0,  0, -1};
    vecs[3] = '{0, 0, 0, 0,  1, 0, 3, 0,  1, 5};
    vecs[4] = '{1, 0, 2, 0,  1, 1, 1, 12, 0, 10};
    vecs[5] = '{0, 0, 0, 0,  1, 1, 1, 12, 1, -1};
    vecs[6] = '{1, 0, 1, 0,  1, 0, 3, 0,  0, 12};
    vecs[7] = '{1, 0, 0, 0,  1, 0, 3, 0,  1, 5};
    vecs[8] = '{1, 0, 0, 0,  0, 0, 0, 0,  0, 3};
    foreach (vecs[i]) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      wait_ack(port, cyc);
      check("vec_port", port, vecs[i].exp_port);
      if (vecs[i].exp_rdata >= 0)
        check("vec_rdata", (port == 1) ? int'(rdata1) : int'(rdata0), vecs[i].exp_rdata);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Randomized traffic against a transaction-level model
    shadow = '{4'h3, 4'hC, 4'hA, 4'h5};
    pend = '{0, 0};
    model_last = 0;
    just_acked = 0;
    for (int n = 0; n < 200; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 9) < 6) begin
          pend[p] = 1;
          op_we[p] = 1'($urandom_range(0, 1));
          op_addr[p] = int'($urandom_range(0, 3));
          op_data[p] = int'($urandom_range(0, 15));
        end
      end
      if (!pend[0] && !pend[1]) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        just_acked = 0;
        continue;
      end
      drive(pend[0], op_we[0], op_addr[0], op_data[0],
            pend[1], op_we[1], op_addr[1], op_data[1]);
      winner = (pend[0] && pend[1]) ? 1 - model_last : (pend[1] ? 1 : 0);
      exp_lat = just_acked ? 3 : 2;
      wait_ack(port, cyc);
      check("rand_port", port, winner);
      check("rand_latency", cyc, exp_lat);
      if (port != winner) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("FAIL rand_abort: got port %0d expected %0d, stopping random phase", port, winner);
        break;
      end
      if (op_we[winner]) shadow[op_addr[winner]] = 4'(op_data[winner]);
      else check("rand_rdata", (winner == 1) ? int'(rdata1) : int'(rdata0),
                 int'(shadow[op_addr[winner]]));
      pend[winner] = 0;
      model_last = winner;
      just_acked = 1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the 4-word x 4-bit register file.
- Lets two independent requesters (e.g. switch-input logic and display scanner) share the file's single write port and single read port.
- Each requester issues one read or write per req/ack handshake.
- The block drives every file control signal and returns read data.

Parameters:
- DATA_W, 4, data width of the file words and of the requester data buses.
- ADDR_W, 2, file address width (2^ADDR_W words).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 op: 1 = write, 0 = read; stable while req0 is high.
- addr0  input  ADDR_W  port 0 word address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  one-cycle completion pulse for port 0.
- rdata0  output  DATA_W  port 0 read data; valid with ack0 and held until port 0's next read.
- req1, we1, addr1, wdata1, ack1, rdata1: same as the port 0 signals, for port 1.
- file_in  output  DATA_W  data to the file's write input.
- file_waddr  output  ADDR_W  file write address.
- file_raddr  output  ADDR_W  file read address.
- file_write  output  1  file write enable.
- file_out  input  DATA_W  file read data (combinational read from file_raddr).
- busy  output  1  high while a transaction is in ACCESS or RESP.

Behaviour:
- Interface: one clock, clk; reset clr is synchronous and active-high.
- On clr: state=IDLE; ack0, ack1, rdata0, rdata1, busy, file_write all 0; latched op/addr/data 0; last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port != last_grant.
  - On grant: latch winner id, we, addr, wdata; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - file_waddr = file_raddr = latched addr; file_in = latched wdata.
  - file_write = latched we; the file commits the write at the closing edge.
  - For a read, file_out is captured into the winner's rdata at the closing edge.
  - Go to RESP.
- RESP (1 cycle):
  - Winner's ack=1; loser's ack stays 0.
  - last_grant <= winner; go to IDLE.
- busy=1 in ACCESS and RESP.
- Latency: req sampled high in IDLE at cycle n -> ACCESS at n+1 -> ack at n+2. Throughput: one transaction per 3 cycles.
- Requester rule: drop req (or present a new op) on the edge after seeing ack. req is only sampled in IDLE, so a request changing during ACCESS/RESP has no effect.
- Output timing: all outputs come from registered state and latched fields; there is no combinational path from req/we/addr/wdata to any output.
- file_write is 0 in IDLE and RESP and on every read.
- Write then read of the same address: the read (next grant) returns the new value, because the write committed in an earlier ACCESS.
- Loser fairness: a waiting port is granted next whenever the other port re-requests. Max wait is one transaction.
- clr mid-operation:
  - clr sampled during ACCESS or RESP returns the FSM to IDLE with no ack.
  - The aborted requester must re-request.
  - rdata for an aborted read is 0, from reset.
- Address wrap: addr is used as given, so all 2^ADDR_W words are reachable; no range checking.

Test Plan:
1. clr=1 for 2 cycles with req0=req1=1 -> ack0=ack1=0, busy=0, file_write=0, rdata0=rdata1=0. After release, port 0 is granted first.
2. req0=1, we0=1, addr0=2, wdata0=0xA at cycle 0 -> cycle 1: file_write=1, file_waddr=2, file_in=0xA. Cycle 2: ack0=1. file_write is high for exactly 1 cycle.
3. After test 2, req1=1, we1=0, addr1=2 -> file_raddr=2 in ACCESS. At ack1, rdata1=0xA; rdata1 holds 0xA after ack1 falls; file_write stays 0.
4. req0 and req1 both held high continuously, writes to addr 0 and 1 respectively -> acks alternate ack0, ack1, ack0, ack1, spaced 3 cycles apart.
5. Port 0 writes addr3=0x5 while port 1 simultaneously requests a read of addr3 -> port 0 is served first (tie after reset), then port 1 receives rdata1=0x5.
6. req0 read of addr1; assert clr during the ACCESS cycle -> no ack0, state IDLE, busy=0 the next cycle, rdata0=0. Re-issuing req0 completes normally 2 cycles later.
